// File: rtl/cmp_framer_pkg.sv
// Shared types, field layout and word packing for the comparator delay framer.
//
// Word layout (32 bits):
//   [31:28] header   [27] S11 timeout   [26] S21 timeout
//   [25:13] S11 delay   [12:0] S21 delay
package cmp_framer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        EMIT    = 2'd2
    } state_t;

    localparam int unsigned DELAY_W = 13;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned HDR_W   = 4;
    localparam int unsigned HDR_LSB = 28;
    localparam int unsigned T11_BIT = 27;
    localparam int unsigned T21_BIT = 26;
    localparam int unsigned D11_LSB = 13;
    localparam int unsigned D21_LSB = 0;

    // Packs flags and delays; header bits are left zero for the caller to fill.
    function automatic logic [WORD_W-1:0] pack_word(
        input logic               t11,
        input logic               t21,
        input logic [DELAY_W-1:0] d11,
        input logic [DELAY_W-1:0] d21
    );
        logic [WORD_W-1:0] w;
        w                     = '0;
        w[T11_BIT]            = t11;
        w[T21_BIT]            = t21;
        w[D11_LSB +: DELAY_W] = d11;
        w[D21_LSB +: DELAY_W] = d21;
        return w;
    endfunction

endpackage

// File: rtl/cmp_word_fifo.sv
// Synchronous show-ahead FIFO for result words. The head entry is always
// visible on dout; a push while full is accepted only alongside a pop.
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   push, din   write request and data
//   pop         read request (ignored while empty)
//   dout        head entry
//   full, empty registered occupancy flags
module cmp_word_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             do_push;
    logic             do_pop;

    // Pop frees a slot in the same cycle, so a full FIFO can still take a push.
    always_comb begin
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        count_d = CW'(count_q + CW'(do_push) - CW'(do_pop));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= AW'(wr_ptr + 1'b1);
            end
            if (do_pop) begin
                rd_ptr <= AW'(rd_ptr + 1'b1);
            end
            count_q <= count_d;
            full    <= (count_d == CW'(DEPTH));
            empty   <= (count_d == '0);
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/cmp_delay_framer.sv
// Measures the delay, in shifting_clk cycles, from a ref comparator rising
// edge to the first S11 and S21 rising edges, packs the result into a 32-bit
// word and queues it for the GTH transmit mux on a valid/ready stream.
//
// Build option: define CMP_GLITCH_FILTER_EN to qualify S11/S21 edges with two
// consecutive high samples after a low; the reported delay is then the cycle
// of the first high sample. ref edge detection is never filtered.
//
// Ports:
//   shifting_clk   sampling clock
//   reset          asynchronous active-high reset
//   enable         arms new measurements (level)
//   cmp_data_ref   registered ref comparator sample
//   cmp_data_s11   registered S11 comparator sample
//   cmp_data_s21   registered S21 comparator sample
//   m_data/m_valid/m_ready  result word stream (FIFO head)
//   busy           a measurement or emit is in progress
//   meas_count     accepted words, saturating
//   drop_count     words dropped on overflow, saturating
module cmp_delay_framer
    import cmp_framer_pkg::*;
#(
    parameter int unsigned TIMEOUT    = 4095,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [3:0]  HEADER     = 4'hA
) (
    input  logic        shifting_clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        cmp_data_ref,
    input  logic        cmp_data_s11,
    input  logic        cmp_data_s21,
    output logic [31:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        busy,
    output logic [15:0] meas_count,
    output logic [7:0]  drop_count
);

    state_t               state_q, state_d;
    logic [DELAY_W-1:0]   cnt_q, cnt_d;
    logic [DELAY_W-1:0]   d11_q, d11_d;
    logic [DELAY_W-1:0]   d21_q, d21_d;
    logic                 got11_q, got11_d;
    logic                 got21_q, got21_d;
    logic                 push_c;
    logic [WORD_W-1:0]    word_c;
    logic [DELAY_W-1:0]   cap_val;
    logic                 ref_p, s11_p, s21_p;
    logic                 ref_rise, s11_hit, s21_hit;
    logic                 fifo_full, fifo_empty;
    logic                 pop_c, accept_c, drop_c;

`ifdef CMP_GLITCH_FILTER_EN
    logic                 s11_pp, s21_pp;
`endif

    // Input sample history for edge detection.
    always_ff @(posedge shifting_clk or posedge reset) begin
        if (reset) begin
            ref_p  <= 1'b0;
            s11_p  <= 1'b0;
            s21_p  <= 1'b0;
`ifdef CMP_GLITCH_FILTER_EN
            s11_pp <= 1'b0;
            s21_pp <= 1'b0;
`endif
        end else begin
            ref_p  <= cmp_data_ref;
            s11_p  <= cmp_data_s11;
            s21_p  <= cmp_data_s21;
`ifdef CMP_GLITCH_FILTER_EN
            s11_pp <= s11_p;
            s21_pp <= s21_p;
`endif
        end
    end

    // Edge qualification and the delay value latched on a hit. cnt_q is 0 in IDLE.
    always_comb begin
        ref_rise = cmp_data_ref & ~ref_p;
`ifdef CMP_GLITCH_FILTER_EN
        s11_hit  = cmp_data_s11 & s11_p & ~s11_pp;
        s21_hit  = cmp_data_s21 & s21_p & ~s21_pp;
        // Qualification lands one cycle after the first high sample.
        cap_val  = (cnt_q == '0) ? '0 : DELAY_W'(cnt_q - 1'b1);
`else
        s11_hit  = cmp_data_s11 & ~s11_p;
        s21_hit  = cmp_data_s21 & ~s21_p;
        cap_val  = cnt_q;
`endif
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d11_d   = d11_q;
        d21_d   = d21_q;
        got11_d = got11_q;
        got21_d = got21_q;
        push_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && ref_rise) begin
                    state_d = MEASURE;
                    cnt_d   = DELAY_W'(1);
                    got11_d = s11_hit;
                    got21_d = s21_hit;
                    d11_d   = cap_val;
                    d21_d   = cap_val;
                end
            end
            MEASURE: begin
                cnt_d = DELAY_W'(cnt_q + 1'b1);
                if (s11_hit && !got11_q) begin
                    got11_d = 1'b1;
                    d11_d   = cap_val;
                end
                if (s21_hit && !got21_q) begin
                    got21_d = 1'b1;
                    d21_d   = cap_val;
                end
                if ((got11_d && got21_d) || (cnt_q == DELAY_W'(TIMEOUT))) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                push_c  = 1'b1;
                state_d = IDLE;
                cnt_d   = '0;
                got11_d = 1'b0;
                got21_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                got11_d = 1'b0;
                got21_d = 1'b0;
            end
        endcase
    end

    // Result word; an uncaptured channel reports TIMEOUT with its flag set.
    always_comb begin
        word_c = pack_word(~got11_q, ~got21_q,
                           got11_q ? d11_q : DELAY_W'(TIMEOUT),
                           got21_q ? d21_q : DELAY_W'(TIMEOUT));
        word_c[HDR_LSB +: HDR_W] = HEADER;
    end

    always_ff @(posedge shifting_clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            d11_q   <= '0;
            d21_q   <= '0;
            got11_q <= 1'b0;
            got21_q <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d11_q   <= d11_d;
            d21_q   <= d21_d;
            got11_q <= got11_d;
            got21_q <= got21_d;
            busy    <= (state_d != IDLE);
        end
    end

    always_comb begin
        pop_c    = m_valid & m_ready;
        accept_c = push_c & (~fifo_full | pop_c);
        drop_c   = push_c & fifo_full & ~pop_c;
    end

    // Saturating accept/drop statistics.
    always_ff @(posedge shifting_clk or posedge reset) begin
        if (reset) begin
            meas_count <= '0;
            drop_count <= '0;
        end else begin
            if (accept_c && (meas_count != 16'hFFFF)) begin
                meas_count <= 16'(meas_count + 1'b1);
            end
            if (drop_c && (drop_count != 8'hFF)) begin
                drop_count <= 8'(drop_count + 1'b1);
            end
        end
    end

    cmp_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (shifting_clk),
        .rst   (reset),
        .push  (push_c),
        .pop   (pop_c),
        .din   (word_c),
        .dout  (m_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign m_valid = ~fifo_empty;

endmodule

// File: tb/tb_cmp_delay_framer.sv
// Scoreboard bench for cmp_delay_framer. Stimulus waveforms are built per
// measurement; a reference model scans them for the first qualifying edge and
// queues the expected word, and a monitor checks the stream every cycle.
module tb_cmp_delay_framer;

    localparam int unsigned TO    = 100;
    localparam int unsigned DEPTH = 8;
    localparam int          MAXL  = TO + 10;
    localparam logic [3:0]  HDR   = 4'hA;

    typedef struct {
        int          cyc;
        logic [31:0] w;
    } pend_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        in_ref = 1'b0;
    logic        in_s11 = 1'b0;
    logic        in_s21 = 1'b0;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        busy;
    logic [15:0] meas_count;
    logic [7:0]  drop_count;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    bit          in_rst = 1'b1;
    bit          rdy_rand = 1'b0;
    int          bstart = 1;
    int          bend = 0;
    logic [15:0] exp_meas = '0;
    logic [7:0]  exp_drop = '0;
    logic [31:0] sb[$];
    pend_t       pend[$];

    bit w11 [MAXL];
    bit w21 [MAXL];
    bit wref[MAXL];
    bit wen [MAXL];

    cmp_delay_framer #(
        .TIMEOUT    (TO),
        .FIFO_DEPTH (DEPTH),
        .HEADER     (HDR)
    ) dut (
        .shifting_clk (clk),
        .reset        (reset),
        .enable       (enable),
        .cmp_data_ref (in_ref),
        .cmp_data_s11 (in_s11),
        .cmp_data_s21 (in_s21),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .busy         (busy),
        .meas_count   (meas_count),
        .drop_count   (drop_count)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: compares stream, busy and counters, and advances the model FIFO.
    logic [31:0] mon_w;
    bit          mon_valid, mon_pop, mon_full;
    always @(negedge clk) begin
        if (!in_rst) begin
            mon_valid = (sb.size() > 0);
            chk("m_valid", 32'(m_valid), 32'(mon_valid));
            chk("busy", 32'(busy), 32'((cyc >= bstart) && (cyc <= bend)));
            chk("meas_count", 32'(meas_count), 32'(exp_meas));
            chk("drop_count", 32'(drop_count), 32'(exp_drop));
            if (mon_valid) chk("m_data", m_data, sb[0]);
            mon_pop  = mon_valid && (m_ready === 1'b1);
            mon_full = (sb.size() == DEPTH);
            if (mon_pop) mon_w = sb.pop_front();
            if (pend.size() > 0 && pend[0].cyc == cyc) begin
                if (!mon_full || mon_pop) begin
                    sb.push_back(pend[0].w);
                    if (exp_meas != 16'hFFFF) exp_meas++;
                end else if (exp_drop != 8'hFF) begin
                    exp_drop++;
                end
                void'(pend.pop_front());
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_rand) m_ready = 1'($urandom_range(0, 1));
    end

    function automatic bit smp(input int ch, input int i);
        if (i < 0 || i >= MAXL) return 1'b0;
        return (ch == 0) ? w11[i] : w21[i];
    endfunction

    // First offset, 0..TO, where the channel shows a qualifying edge.
    function automatic int first_hit(input int ch);
        for (int k = 0; k <= int'(TO); k++) begin
`ifdef CMP_GLITCH_FILTER_EN
            if (smp(ch, k) && smp(ch, k - 1) && !smp(ch, k - 2)) return k;
`else
            if (smp(ch, k) && !smp(ch, k - 1)) return k;
`endif
        end
        return -1;
    endfunction

    function automatic int delay_of(input int k);
`ifdef CMP_GLITCH_FILTER_EN
        return (k == 0) ? 0 : k - 1;
`else
        return k;
`endif
    endfunction

    task automatic put(input int ch, input int i, input bit v);
        if (i >= 0 && i < MAXL) begin
            if (ch == 0) w11[i] = v;
            else         w21[i] = v;
        end
    endtask

    task automatic rise(input int ch, input int r);
        for (int i = r; i < MAXL; i++) put(ch, i, 1'b1);
    endtask

    task automatic clear_w();
        for (int i = 0; i < MAXL; i++) begin
            w11[i] = 1'b0; w21[i] = 1'b0; wref[i] = 1'b0; wen[i] = 1'b1;
        end
        wref[0] = 1'b1;
    endtask

    task automatic gen_ch(input int ch);
        int r;
        case ($urandom_range(0, 4))
            0: rise(ch, $urandom_range(0, TO + 5));
            1: begin
                r = $urandom_range(0, 40);
                put(ch, r, 1'b1);
                rise(ch, r + 2 + $urandom_range(0, 30));
            end
            2: ;
            3: rise(ch, $urandom_range(TO - 2, TO + 1));
            default: begin
                r = $urandom_range(0, 10);
                rise(ch, r);
                put(ch, r + $urandom_range(1, 5), 1'b0);
            end
        endcase
    endtask

    task automatic gen_random();
        clear_w();
        gen_ch(0);
        gen_ch(1);
        for (int i = 1; i < MAXL; i++) begin
            wref[i] = ($urandom_range(0, 3) == 0);
            wen[i]  = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic idle_low(input int n);
        in_ref = 1'b0; in_s11 = 1'b0; in_s21 = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Drives one measurement (called at posedge+1) and queues its expected word.
    task automatic run_scn(input bit lit_en, input logic [31:0] lit);
        int k11, k21, endoff, c0;
        logic [31:0] w;
        pend_t p;
        k11 = first_hit(0);
        k21 = first_hit(1);
        if (k11 >= 0 && k21 >= 0) begin
            endoff = (k11 > k21) ? k11 : k21;
            if (endoff < 1) endoff = 1;
        end else begin
            endoff = TO;
        end
        w = {HDR, 1'(k11 < 0), 1'(k21 < 0),
             13'((k11 < 0) ? int'(TO) : delay_of(k11)),
             13'((k21 < 0) ? int'(TO) : delay_of(k21))};
        if (lit_en) w = lit;
        c0 = cyc;
        p.cyc = c0 + endoff + 1;
        p.w   = w;
        pend.push_back(p);
        bstart = c0 + 1;
        bend   = c0 + endoff + 1;
        for (int i = 0; i <= endoff + 1; i++) begin
            in_ref = wref[i]; enable = wen[i]; in_s11 = w11[i]; in_s21 = w21[i];
            @(posedge clk);
            #1;
        end
        enable = 1'b1;
        idle_low(3);
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear immediately.
    task automatic do_reset();
        in_rst = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_data", m_data, 32'd0);
        chk("rst_meas", 32'(meas_count), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        in_ref = 1'b0; in_s11 = 1'b0; in_s21 = 1'b0; enable = 1'b0;
        sb.delete(); pend.delete();
        exp_meas = '0; exp_drop = '0; bstart = 1; bend = 0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        in_rst = 1'b0;
        enable = 1'b1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() > 0 || pend.size() > 0) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("drain", 32'(sb.size() + pend.size()), 32'd0);
    endtask

    initial begin
        @(posedge clk); #1;
        do_reset();
        m_ready = 1'b1;

        clear_w(); rise(0, 5); rise(1, 20);
        run_scn(1'b1, 32'hA000A014);
        chk("meas_after_first", 32'(meas_count), 32'd1);

        clear_w(); rise(0, 0); rise(1, 1);
        run_scn(1'b1, 32'hA0000001);

        clear_w(); rise(1, 3);
        run_scn(1'b1, 32'hA80C8003);

`ifdef CMP_GLITCH_FILTER_EN
        clear_w(); put(0, 2, 1'b1); rise(0, 6); rise(1, 9);
        run_scn(1'b1, 32'hA000C009);
`endif

        // ref edge while disabled must not start a measurement.
        enable = 1'b0; in_ref = 1'b1;
        @(posedge clk); #1;
        in_s11 = 1'b1; in_s21 = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        enable = 1'b1;
        idle_low(3);
        wait_drain();

        rdy_rand = 1'b1;
        repeat (40) begin
            gen_random();
            run_scn(1'b0, 32'd0);
        end
        rdy_rand = 1'b0;
        m_ready = 1'b1;
        wait_drain();

        // Overflow: 10 words into an 8-deep FIFO with no consumer.
        do_reset();
        m_ready = 1'b0;
        repeat (10) begin
            clear_w();
            rise(0, $urandom_range(0, 8));
            rise(1, $urandom_range(0, 8));
            run_scn(1'b0, 32'd0);
        end
        chk("ovf_drop", 32'(drop_count), 32'd2);
        chk("ovf_meas", 32'(meas_count), 32'd8);
        chk("ovf_held", 32'(sb.size()), 32'd8);
        m_ready = 1'b1;
        wait_drain();
        repeat (3) begin @(posedge clk); #1; end

        // Reset in the middle of a measurement, with words still queued.
        m_ready = 1'b0;
        repeat (2) begin
            clear_w(); rise(0, 2); rise(1, 4);
            run_scn(1'b0, 32'd0);
        end
        bstart = cyc + 1;
        bend   = cyc + 100000;
        in_ref = 1'b1; enable = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(posedge clk); #1;
            in_ref = 1'b0;
            if (i >= 3) in_s11 = 1'b1;
        end
        do_reset();
        repeat (20) begin
            in_s11 = 1'($urandom_range(0, 1));
            in_s21 = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        idle_low(3);
        m_ready = 1'b1;
        clear_w(); rise(0, 1); rise(1, 7);
        run_scn(1'b0, 32'd0);
        wait_drain();
        chk("end_meas", 32'(meas_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cmp_delay_framer.md
Name: cmp_delay_framer

Overview:
- Sits between the registered comparator samples (ref, S11, S21) and the 32-bit GTH transmit data path.
- Measures, in `shifting_clk` cycles, the delay from a ref comparator rising edge to the first S11 and S21 rising edges.
- Packs each measurement into one 32-bit word and buffers it in a small FIFO.
- Presents words on a valid/ready stream to the GTH data mux.

Parameters:
- `TIMEOUT`, 4095: max delay count per measurement; legal range 1..8191.
- `FIFO_DEPTH`, 8: result FIFO entries; power of 2, minimum 2.
- `HEADER`, 4'hA: constant placed in word bits [31:28].

Ports:
- `shifting_clk`  in  1  sampling clock, all logic in this domain
- `reset`  in  1  asynchronous, active-high reset
- `enable`  in  1  arms new measurements; level-sensitive
- `cmp_data_ref`  in  1  registered ref comparator sample
- `cmp_data_s11`  in  1  registered S11 comparator sample
- `cmp_data_s21`  in  1  registered S21 comparator sample
- `m_data`  out  32  result word (FIFO head)
- `m_valid`  out  1  FIFO non-empty
- `m_ready`  in  1  consumer accepts `m_data` this cycle
- `busy`  out  1  FSM not in IDLE
- `meas_count`  out  16  words pushed, saturating at 0xFFFF
- `drop_count`  out  8  words dropped on overflow, saturating at 0xFF

Behaviour:
- Reset: asynchronous, active-high, one clock (`shifting_clk`).
  - On assertion: FSM=IDLE, FIFO empty, `m_valid`=0, `busy`=0, counters=0, edge-history registers=0, `m_data`=0.
  - Assertion mid-measurement discards that measurement; no word is produced.
- Edge detect: each input has a previous-sample register. Rising edge = cur & ~prev.
- IDLE:
  - ref rising edge while `enable`=1 → MEASURE, with `cnt`=0 in that same cycle.
  - S11/S21 edges in that same cycle are captured with delay 0.
- MEASURE:
  - `cnt` increments by 1 per cycle.
  - First S11 rising edge latches `d11`=`cnt` and sets `got11`; first S21 edge does likewise into `d21`/`got21`.
  - Later edges are ignored. ref edges are ignored.
  - Deasserting `enable` does not abort the measurement.
  - Exit to EMIT when `got11`&`got21`, or when `cnt`==`TIMEOUT`.
  - Any channel not captured at timeout: delay field=`TIMEOUT`, timeout flag=1.
  - An edge arriving exactly at `cnt`==`TIMEOUT` counts as captured (flag=0).
- EMIT (1 cycle): push word, then → IDLE.
  - A ref edge in the EMIT cycle is ignored; re-arm happens in the next IDLE cycle.
- Word format:
  - [31:28] `HEADER`
  - [27] S11 timeout
  - [26] S21 timeout
  - [25:13] `d11`
  - [12:0] `d21`
- Latency: measurement ends at cycle N; push at N+1; `m_valid` high at N+2 if the FIFO was empty.
- FIFO: show-ahead; `m_data` is the head entry.
  - Pop on `m_valid`&`m_ready`.
  - Push when full is accepted only if a pop occurs in the same cycle; otherwise the word is dropped and `drop_count` increments.
  - `meas_count` increments only on accepted pushes.
  - Both counters saturate.
  - Empty + push: head updates; `m_valid` rises next cycle.
  - `m_ready` while empty: no effect.
- `m_data` holds its value while `m_valid`&!`m_ready`.
- `busy`=1 in MEASURE and EMIT.

Optional Feature:
- `CMP_GLITCH_FILTER_EN`, defined:
  - S11/S21 edges are qualified only by two consecutive high samples after a low (pattern 0,1,1).
  - Latched delay = `cnt` at qualification - 1, i.e. the cycle of the first high sample.
  - A qualification at `cnt`==0 reports 0.
  - A single-cycle high pulse is ignored.
  - ref edge detection is unfiltered.
- `CMP_GLITCH_FILTER_EN` undefined: plain single-sample rising-edge detection as above.

Decomposition:
- Package `cmp_framer_pkg`:
  - FSM state enum (IDLE, MEASURE, EMIT)
  - Delay field width constant (13)
  - Bit-position constants for header, flags and delay fields
  - Function `pack_word(t11, t21, d11, d21)`
- Sub-module `cmp_word_fifo`: synchronous show-ahead FIFO.
  - Parameterised width/depth.
  - Ports: push, pop, full, empty, data in/out.

Test Plan:
- ref rises; S11 rises 5 cycles later; S21 20 cycles later; `m_ready`=1 → one word 0xA000A014, `meas_count`=1.
- `TIMEOUT`=100; ref rises; S21 at +3; S11 never → word 0xA80C8003.
- S11 rises in the same cycle as the ref edge; S21 at +1 → word 0xA0000001.
- `m_ready`=0; 10 complete measurements → 8 words held, `drop_count`=2; raise `m_ready` → 8 words drained in order, then `m_valid`=0.
- Reset asserted at `cnt`=7 of a measurement → `busy`, `m_valid` and counters go to 0 asynchronously; no word appears after release.
- With `CMP_GLITCH_FILTER_EN`: 1-cycle S11 pulse at +2, then S11 high from +6 onward, S21 high from +9 onward → word 0xA000C009.
